// File: rtl/spi_pkg.sv
// Shared opcode definitions for the SPI RAM endpoint.
// The opcode occupies the top OP_W bits of each framed word.
package spi_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SET_WR = 2'b00,
        OP_WRITE  = 2'b01,
        OP_SET_RD = 2'b10,
        OP_READ   = 2'b11
    } op_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM with registered read.
// rdata only updates on re, so it doubles as the tx holding register.
module spi_ram_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoded RAM endpoint: address counters, error flag and
// tx handshake around a single-port RAM.
module spi_ram_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W+OP_W-1:0] din,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   auto_inc,
    output logic [DATA_W-1:0]      dout,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   err
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              tx_valid_q;
    logic              dout_zero;
    logic              err_q;

    op_e               op;
    logic [DATA_W-1:0] payload;
    logic              accept;
    logic              is_set_wr;
    logic              is_wr;
    logic              is_set_rd;
    logic              is_rd;
    logic              wr_ok;
    logic              rd_ok;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;

    function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    assign op       = op_e'(din[DATA_W+OP_W-1:DATA_W]);
    assign payload  = din[DATA_W-1:0];
    assign rx_ready = ~tx_valid_q | tx_ready;
    assign accept   = rx_valid & rx_ready;

    assign is_set_wr = accept && (op == OP_SET_WR);
    assign is_wr     = accept && (op == OP_WRITE);
    assign is_set_rd = accept && (op == OP_SET_RD);
    assign is_rd     = accept && (op == OP_READ);

    assign wr_ok = {1'b0, wr_addr} < DEPTH_L;
    assign rd_ok = {1'b0, rd_addr} < DEPTH_L;

    // Out-of-range accesses never reach the array.
    assign mem_we   = is_wr & wr_ok;
    assign mem_re   = is_rd & rd_ok;
    assign mem_addr = is_rd ? rd_addr : wr_addr;

    spi_ram_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (payload),
        .rdata (mem_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            tx_valid_q <= 1'b0;
            dout_zero  <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            if (is_set_wr) begin
                wr_addr <= payload[ADDR_W-1:0];
            end else if (is_wr && auto_inc) begin
                wr_addr <= bump(wr_addr);
            end

            if (is_set_rd) begin
                rd_addr <= payload[ADDR_W-1:0];
            end else if (is_rd && auto_inc) begin
                rd_addr <= bump(rd_addr);
            end

            if (is_rd) begin
                tx_valid_q <= 1'b1;
                dout_zero  <= ~rd_ok;
            end else if (tx_valid_q && tx_ready) begin
                tx_valid_q <= 1'b0;
            end

            if ((is_wr && !wr_ok) || (is_rd && !rd_ok)) begin
                err_q <= 1'b1;
            end
        end
    end

    // RAM output is masked after reset and on out-of-range reads.
    assign dout     = dout_zero ? '0 : mem_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: a full-depth and a 200-entry instance
// share stimulus; the short one exercises out-of-range handling.
module tb_spi_ram_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic       auto_inc;
    logic       tx_ready;

    logic       rx_ready;
    logic [7:0] dout;
    logic       tx_valid;
    logic       err;

    logic       rx_ready2;
    logic [7:0] dout2;
    logic       tx_valid2;
    logic       err2;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] SWR = 2'b00;
    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] SRD = 2'b10;
    localparam logic [1:0] RD  = 2'b11;

    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .auto_inc (auto_inc),
        .dout     (dout),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .err      (err)
    );

    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut200 (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready2),
        .auto_inc (auto_inc),
        .dout     (dout2),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready),
        .err      (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
        din      = {op, pl};
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        auto_inc = 1'b0;
        tx_ready = 1'b1;
        tick();
        tick();
        chk("rst_dout", dout, 8'h00);
        chk("rst_tv", tx_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rxr", rx_ready, 1'b1);
        chk("rst_err2", err2, 1'b0);
        rst_n = 1'b1;
        tick();

        // plain write / read
        cmd(SWR, 8'h05);
        cmd(WR, 8'hA5);
        cmd(SRD, 8'h05);
        chk("pre_read_tv", tx_valid, 1'b0);
        cmd(RD, 8'h00);
        chk("rd1_tv", tx_valid, 1'b1);
        chk("rd1_dout", dout, 8'hA5);
        chk("rd1_err", err, 1'b0);
        tick();
        chk("rd1_drop", tx_valid, 1'b0);

        // burst with wrap at DEPTH-1
        auto_inc = 1'b1;
        cmd(SWR, 8'hFE);
        cmd(WR, 8'h11);
        cmd(WR, 8'h22);
        cmd(WR, 8'h33);
        cmd(SRD, 8'hFE);
        cmd(RD, 8'h00);
        chk("bst_d0", dout, 8'h11);
        chk("bst_v0", tx_valid, 1'b1);
        cmd(RD, 8'h00);
        chk("bst_d1", dout, 8'h22);
        chk("bst_v1", tx_valid, 1'b1);
        cmd(RD, 8'h00);
        chk("bst_d2", dout, 8'h33);
        chk("bst_v2", tx_valid, 1'b1);
        tick();
        chk("bst_drop", tx_valid, 1'b0);

        // backpressure
        cmd(SWR, 8'h06);
        cmd(WR, 8'h66);
        cmd(WR, 8'h77);
        cmd(WR, 8'h88);
        cmd(WR, 8'h99);
        cmd(WR, 8'hAA);
        cmd(SRD, 8'h05);
        auto_inc = 1'b0;
        tx_ready = 1'b0;
        cmd(RD, 8'h00);
        chk("bp_dout", dout, 8'hA5);
        din      = {RD, 8'h00};
        rx_valid = 1'b1;
        auto_inc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rxr", rx_ready, 1'b0);
            tick();
            chk("bp_tv", tx_valid, 1'b1);
            chk("bp_hold", dout, 8'hA5);
        end
        tx_ready = 1'b1;
        #1;
        chk("bp_rxr_up", rx_ready, 1'b1);
        tick();
        chk("bp_acc", dout, 8'hA5);
        auto_inc = 1'b0;
        tick();
        chk("bp_next", dout, 8'h66);
        chk("bp_next_tv", tx_valid, 1'b1);

        // non-READ while output is held
        din = {WR, 8'hBB};
        tick();
        rx_valid = 1'b0;
        chk("nr_drop", tx_valid, 1'b0);
        chk("nr_dout", dout, 8'h66);
        cmd(SRD, 8'h0B);
        cmd(RD, 8'h00);
        chk("nr_land", dout, 8'hBB);
        tick();

        // write then immediate read of same address
        cmd(SRD, 8'h10);
        cmd(SWR, 8'h10);
        cmd(WR, 8'h3C);
        cmd(RD, 8'h00);
        chk("ord", dout, 8'h3C);
        tick();

        // reset during held output
        cmd(SRD, 8'h05);
        tx_ready = 1'b0;
        cmd(RD, 8'h00);
        chk("mr_tv", tx_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("mr_tv0", tx_valid, 1'b0);
        chk("mr_dout", dout, 8'h00);
        chk("mr_err", err, 1'b0);
        chk("mr_rxr", rx_ready, 1'b1);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        cmd(RD, 8'h00);
        chk("mr_keep", dout, 8'h33);
        cmd(WR, 8'h44);
        cmd(RD, 8'h00);
        chk("mr_wr0", dout, 8'h44);
        chk("mr_err2", err2, 1'b0);
        tick();

        // out of range on the 200-entry instance
        cmd(SWR, 8'hC8);
        cmd(WR, 8'h7E);
        chk("oor_err2", err2, 1'b1);
        chk("oor_err", err, 1'b0);
        cmd(SRD, 8'hD0);
        cmd(RD, 8'h00);
        chk("oor_dout2", dout2, 8'h00);
        chk("oor_tv2", tx_valid2, 1'b1);
        chk("oor_err2b", err2, 1'b1);
        tick();
        chk("oor_drop2", tx_valid2, 1'b0);

        // wrap at DEPTH-1 for the short instance
        auto_inc = 1'b1;
        cmd(SWR, 8'hC7);
        cmd(WR, 8'h5A);
        cmd(WR, 8'h5B);
        cmd(SRD, 8'hC7);
        cmd(RD, 8'h00);
        chk("wr_d0", dout, 8'h5A);
        chk("wr_d0_2", dout2, 8'h5A);
        cmd(RD, 8'h00);
        chk("wr_d1", dout, 8'h5B);
        chk("wr_d1_2", dout2, 8'h5B);
        chk("wr_sticky", err2, 1'b1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
